// File: rtl/psum_pkg.sv
// Elaboration-time helpers shared by the psum adder tree: log2, pipeline depth
// and per-level sum widths.
package psum_pkg;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int x = 1; x < v; x = x * 2) r++;
    return r;
  endfunction

  // One register stage per tree row plus the final fifo-add stage.
  function automatic int levels(input int num_pe);
    return clog2(num_pe) + 1;
  endfunction

  // Width of a sum produced at tree level k; wide enough that the tree cannot overflow.
  function automatic int level_width(input int data_width, input int k);
    return data_width + k + 1;
  endfunction

endpackage

// File: rtl/psum_approx_add.sv
// Combinational signed adder, exact or lower-part-OR approximate: the low
// APPROX_BITS are ORed and their top-bit AND is injected as carry into the exact upper part.
module psum_approx_add #(
  parameter int IN_W        = 25,
  parameter int APPROX_BITS = 6
) (
  input  logic [IN_W-1:0] a,
  input  logic [IN_W-1:0] b,
  input  logic            approx_en,
  output logic [IN_W:0]   sum
);

  logic [IN_W:0] a_ext;
  logic [IN_W:0] b_ext;
  logic [IN_W:0] exact;

  assign a_ext = {a[IN_W-1], a};
  assign b_ext = {b[IN_W-1], b};
  assign exact = a_ext + b_ext;

  if (APPROX_BITS == 0) begin : g_exact
    assign sum = exact;
  end else begin : g_approx
    localparam int N = APPROX_BITS;
    logic [IN_W-N:0] upper;
    logic            carry;
    assign carry = a[N-1] & b[N-1];
    assign upper = a_ext[IN_W:N] + b_ext[IN_W:N] + {{(IN_W-N){1'b0}}, carry};
    assign sum   = approx_en ? {upper, a[N-1:0] | b[N-1:0]} : exact;
  end

endmodule

// File: rtl/psum_add_tree_pipe.sv
// Elastic pipelined psum reduction: NUM_PE PE psums plus one FIFO psum into one
// DATA_WIDTH result, with per-beat approximate mode, saturation and overflow count.
module psum_add_tree_pipe
  import psum_pkg::*;
#(
  parameter int DATA_WIDTH  = 25,
  parameter int NUM_PE      = 4,
  parameter int APPROX_BITS = 6,
  parameter int SAT_EN      = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [NUM_PE*DATA_WIDTH-1:0] pe_data,
  input  logic [DATA_WIDTH-1:0]        fifo_data,
  input  logic                         approx_en,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic                         out_ovf,
  output logic [15:0]                  ovf_cnt
);

  localparam int LEVELS      = levels(NUM_PE);
  localparam int TREE_STAGES = LEVELS - 1;
  localparam int ROOT_W      = DATA_WIDTH + LEVELS - 1;
  localparam int W_F         = DATA_WIDTH + LEVELS;

  // Handshake: a beat moves when valid & ready. The whole pipe freezes while the
  // output is valid and not taken; bubbles are never squeezed out.
  logic stall;
  logic adv;
  assign stall    = out_valid & ~out_ready;
  assign adv      = ~stall;
  assign in_ready = adv;

  logic [LEVELS-1:0] vld_q, vld_d;
  logic [LEVELS-1:0] mode_q, mode_d;
  logic [DATA_WIDTH-1:0] fifo_q [TREE_STAGES];
  logic [DATA_WIDTH-1:0] fifo_d [TREE_STAGES];

  // Bit k of mode_d is the mode of the beat entering stage k, so it also drives that row's adders.
  always_comb begin
    vld_d     = {vld_q[LEVELS-2:0], in_valid};
    mode_d    = {mode_q[LEVELS-2:0], approx_en};
    fifo_d[0] = fifo_data;
    for (int i = 1; i < TREE_STAGES; i++) fifo_d[i] = fifo_q[i-1];
  end

  genvar k, j;
  for (k = 0; k < TREE_STAGES; k++) begin : g_lvl
    localparam int SW = level_width(DATA_WIDTH, k);
    localparam int NN = NUM_PE >> (k + 1);
    logic [SW-1:0] sum_d [NN];
    logic [SW-1:0] sum_q [NN];

    for (j = 0; j < NN; j++) begin : g_node
      logic [SW-2:0] a;
      logic [SW-2:0] b;
      if (k == 0) begin : g_in
        assign a = pe_data[(2*j)*DATA_WIDTH +: DATA_WIDTH];
        assign b = pe_data[(2*j+1)*DATA_WIDTH +: DATA_WIDTH];
      end else begin : g_up
        assign a = g_lvl[k-1].sum_q[2*j];
        assign b = g_lvl[k-1].sum_q[2*j+1];
      end
      psum_approx_add #(.IN_W(SW-1), .APPROX_BITS(APPROX_BITS)) u_add (
        .a         (a),
        .b         (b),
        .approx_en (mode_d[k]),
        .sum       (sum_d[j])
      );
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int i = 0; i < NN; i++) sum_q[i] <= '0;
      end else if (adv) begin
        for (int i = 0; i < NN; i++) sum_q[i] <= sum_d[i];
      end
    end
  end

  logic [ROOT_W-1:0]     root;
  logic [ROOT_W-1:0]     fifo_ext;
  logic [W_F-1:0]        sum_f;
  logic [W_F-DATA_WIDTH:0] sum_hi;
  logic                  ovf;
  logic [DATA_WIDTH-1:0] out_data_d, out_data_q;
  logic                  out_ovf_d, out_ovf_q;
  logic [15:0]           ovf_cnt_d, ovf_cnt_q;

  assign root     = g_lvl[TREE_STAGES-1].sum_q[0];
  assign fifo_ext = {{(LEVELS-1){fifo_q[TREE_STAGES-1][DATA_WIDTH-1]}}, fifo_q[TREE_STAGES-1]};

  psum_approx_add #(.IN_W(ROOT_W), .APPROX_BITS(APPROX_BITS)) u_final (
    .a         (root),
    .b         (fifo_ext),
    .approx_en (mode_d[LEVELS-1]),
    .sum       (sum_f)
  );

  // In range iff every bit from the DATA_WIDTH sign position upward agrees.
  assign sum_hi = sum_f[W_F-1:DATA_WIDTH-1];

  always_comb begin
    ovf        = ~((&sum_hi) | ~(|sum_hi));
    out_data_d = sum_f[DATA_WIDTH-1:0];
    out_ovf_d  = ovf;
    if (ovf && SAT_EN != 0) begin
      out_data_d = sum_f[W_F-1] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                : {1'b0, {(DATA_WIDTH-1){1'b1}}};
    end
    ovf_cnt_d = ovf_cnt_q;
    if (out_valid && out_ready && out_ovf_q && ovf_cnt_q != 16'hFFFF) begin
      ovf_cnt_d = ovf_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q      <= '0;
      mode_q     <= '0;
      out_data_q <= '0;
      out_ovf_q  <= 1'b0;
      for (int i = 0; i < TREE_STAGES; i++) fifo_q[i] <= '0;
    end else if (adv) begin
      vld_q      <= vld_d;
      mode_q     <= mode_d;
      out_data_q <= out_data_d;
      out_ovf_q  <= out_ovf_d;
      for (int i = 0; i < TREE_STAGES; i++) fifo_q[i] <= fifo_d[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ovf_cnt_q <= '0;
    else     ovf_cnt_q <= ovf_cnt_d;
  end

  assign out_valid = vld_q[LEVELS-1];
  assign out_data  = out_data_q;
  assign out_ovf   = out_ovf_q;
  assign ovf_cnt   = ovf_cnt_q;

endmodule

// File: tb/tb_psum_add_tree_pipe.sv
// Bench for psum_add_tree_pipe: default instance (4 PE, approx 6 LSBs, saturating) and an
// 8-PE always-exact instance fed the same accepted beats, both checked against a reference model.
module tb_psum_add_tree_pipe;

  localparam int DW    = 25;
  localparam int NPE   = 4;
  localparam int NPE_B = 8;
  localparam int NB    = 6;
  localparam longint MAXV = (64'sd1 <<< (DW - 1)) - 64'sd1;
  localparam longint MINV = -(64'sd1 <<< (DW - 1));

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic              in_valid, in_ready, approx_en, out_valid, out_ready, out_ovf;
  logic [NPE*DW-1:0] pe_data;
  logic [4*DW-1:0]   pe_hi;
  logic [DW-1:0]     fifo_data, out_data;
  logic [15:0]       ovf_cnt;

  logic                in_valid_b, in_ready_b, out_valid_b, out_ovf_b;
  logic                out_ready_b = 1'b1;
  logic [NPE_B*DW-1:0] pe_data_b;
  logic [DW-1:0]       out_data_b;
  logic [15:0]         ovf_cnt_b;

  assign in_valid_b = in_valid & in_ready;
  assign pe_data_b  = {pe_hi, pe_data};

  psum_add_tree_pipe u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .pe_data(pe_data), .fifo_data(fifo_data), .approx_en(approx_en),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_ovf(out_ovf), .ovf_cnt(ovf_cnt)
  );

  psum_add_tree_pipe #(.DATA_WIDTH(DW), .NUM_PE(NPE_B), .APPROX_BITS(0), .SAT_EN(1)) u_dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .pe_data(pe_data_b), .fifo_data(fifo_data), .approx_en(approx_en),
    .out_valid(out_valid_b), .out_ready(out_ready_b), .out_data(out_data_b),
    .out_ovf(out_ovf_b), .ovf_cnt(ovf_cnt_b)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int exp_ovf = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic longint approx_sum(input longint a, input longint b, input bit mode, input int n);
    longint low, c;
    if (!mode || n == 0) return a + b;
    low = (a | b) & ((64'sd1 <<< n) - 64'sd1);
    c   = ((a >>> (n - 1)) & 64'sd1) & ((b >>> (n - 1)) & 64'sd1);
    return (((a >>> n) + (b >>> n) + c) <<< n) | low;
  endfunction

  function automatic logic [DW:0] ref_result(input logic [NPE_B*DW-1:0] pe, input int npe,
                                             input logic [DW-1:0] fifo, input bit mode, input int n);
    longint v[NPE_B];
    longint s;
    int cnt;
    logic [DW-1:0] d;
    bit o;
    for (int i = 0; i < npe; i++) v[i] = longint'($signed(pe[i*DW +: DW]));
    cnt = npe;
    while (cnt > 1) begin
      for (int i = 0; i < cnt / 2; i++) v[i] = approx_sum(v[2*i], v[2*i+1], mode, n);
      cnt = cnt / 2;
    end
    s = approx_sum(v[0], longint'($signed(fifo)), mode, n);
    o = (s > MAXV) || (s < MINV);
    d = s[DW-1:0];
    if (s > MAXV) d = {1'b0, {(DW-1){1'b1}}};
    if (s < MINV) d = {1'b1, {(DW-1){1'b0}}};
    return {o, d};
  endfunction

  // ---------------- scoreboard ----------------
  logic [DW:0] exp_q[$];
  logic [DW:0] exp_b_q[$];

  always @(negedge clk) begin
    if (!rst) begin
      if (in_valid && in_ready)
        exp_q.push_back(ref_result(pe_data_b, NPE, fifo_data, approx_en, NB));
      if (in_valid_b && in_ready_b)
        exp_b_q.push_back(ref_result(pe_data_b, NPE_B, fifo_data, approx_en, 0));
    end
  end

  bit            hold_chk = 0;
  logic [DW-1:0] held_d;
  logic          held_o;
  logic [DW:0]   e_a, e_b;

  always @(negedge clk) begin
    if (rst) begin
      hold_chk = 0;
    end else begin
      if (hold_chk) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", out_data, held_d);
        check("hold_ovf", out_ovf, held_o);
      end
      hold_chk = out_valid && !out_ready;
      held_d   = out_data;
      held_o   = out_ovf;
      if (out_valid && out_ready) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_out_a: got 0x%0h with empty queue at %0t", out_data, $time);
        end else begin
          e_a = exp_q.pop_front();
          if (out_data !== e_a[DW-1:0] || out_ovf !== e_a[DW]) begin
            n_fail++;
            $display("FAIL out_a: got ovf=%0b data=0x%0h expected ovf=%0b data=0x%0h at %0t",
                     out_ovf, out_data, e_a[DW], e_a[DW-1:0], $time);
          end
          if (e_a[DW] && exp_ovf < 65535) exp_ovf++;
        end
      end
      if (out_valid_b) begin
        n_tests++;
        if (exp_b_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_out_b: got 0x%0h with empty queue at %0t", out_data_b, $time);
        end else begin
          e_b = exp_b_q.pop_front();
          if (out_data_b !== e_b[DW-1:0] || out_ovf_b !== e_b[DW]) begin
            n_fail++;
            $display("FAIL out_b: got ovf=%0b data=0x%0h expected ovf=%0b data=0x%0h at %0t",
                     out_ovf_b, out_data_b, e_b[DW], e_b[DW-1:0], $time);
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input bit v, input logic [NPE*DW-1:0] pe, input logic [4*DW-1:0] hi,
                      input logic [DW-1:0] f, input bit m, input bit r, output bit acc);
    @(posedge clk);
    #1;
    in_valid  = v;
    pe_data   = pe;
    pe_hi     = hi;
    fifo_data = f;
    approx_en = m;
    out_ready = r;
    @(negedge clk);
    check("in_ready", in_ready, !(out_valid && !out_ready));
    acc = v && in_ready;
  endtask

  task automatic send(input logic [NPE*DW-1:0] pe, input logic [4*DW-1:0] hi,
                      input logic [DW-1:0] f, input bit m, input bit rand_rdy);
    bit acc;
    int tries;
    acc   = 0;
    tries = 0;
    while (!acc && tries < 64) begin
      step(1, pe, hi, f, m, rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1, acc);
      tries++;
    end
    if (!acc) check("send_timeout", 0, 1);
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) step(0, pe_data, pe_hi, fifo_data, approx_en, 1'b1, acc);
  endtask

  task automatic drain();
    int c;
    c = 0;
    while ((exp_q.size() != 0 || exp_b_q.size() != 0) && c < 40) begin
      idle(1);
      c++;
    end
    check("drain_a", exp_q.size(), 0);
    check("drain_b", exp_b_q.size(), 0);
    idle(1);
    check("ovf_cnt", ovf_cnt, exp_ovf);
  endtask

  task automatic latency_beat(input logic [NPE*DW-1:0] pe, input logic [4*DW-1:0] hi,
                              input logic [DW-1:0] f, input bit m);
    bit acc;
    int la, lb;
    step(1, pe, hi, f, m, 1'b1, acc);
    check("lat_accept", acc, 1);
    @(posedge clk);
    #1;
    in_valid = 0;
    la = -1;
    lb = -1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (out_valid && la < 0) la = c;
      if (out_valid_b && lb < 0) lb = c;
    end
    check("latency_a", la, 3);
    check("latency_b", lb, 4);
  endtask

  function automatic logic [DW-1:0] rnd_val();
    logic [DW-1:0] v;
    case ($urandom_range(0, 3))
      0:       v = DW'($urandom);
      1:       v = DW'(int'($urandom_range(0, 255)) - 128);
      2:       v = $urandom_range(0, 1) ? {1'b0, {(DW-1){1'b1}}} : {1'b1, {(DW-1){1'b0}}};
      default: v = DW'($urandom_range(0, 4095));
    endcase
    return v;
  endfunction

  logic [NPE*DW-1:0] sp[8];
  logic [DW-1:0]     sf[8];
  logic [NPE*DW-1:0] rp;
  logic [4*DW-1:0]   rh;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    int k;
    rst = 1; in_valid = 0; pe_data = '0; pe_hi = '0; fifo_data = '0; approx_en = 0; out_ready = 1;
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_ovf", out_ovf, 0);
    check("rst_ovf_cnt", ovf_cnt, 0);
    check("rst_in_ready", in_ready, 1);
    @(negedge clk);
    rst = 0;

    // exact sum with latency
    latency_beat({25'd4, 25'd3, 25'd2, 25'd1}, '0, 25'd10, 1'b0);
    // approximate low-part OR, with and without the injected carry
    send({25'd0, 25'd0, 25'd5, 25'd3}, '0, 25'd0, 1'b1, 1'b0);
    send({25'd0, 25'd0, 25'h20, 25'h20}, '0, 25'd0, 1'b1, 1'b0);
    // saturation at both bounds
    send({4{25'h0FFFFFF}}, {4{25'h0FFFFFF}}, 25'h0FFFFFF, 1'b0, 1'b0);
    send({4{25'h1000000}}, {4{25'h1000000}}, 25'h1000000, 1'b0, 1'b0);
    drain();

    // 8-beat stream with a 4-cycle downstream stall
    for (int i = 0; i < 8; i++) begin
      for (int p = 0; p < NPE; p++) sp[i][p*DW +: DW] = rnd_val();
      sf[i] = rnd_val();
    end
    k = 0;
    for (int c = 0; c < 40 && k < 8; c++) begin
      step(1, sp[k], '0, sf[k], k[0], !(c >= 3 && c < 7), acc);
      if (acc) k++;
    end
    check("stream_sent", k, 8);
    drain();

    // per-beat mode interleave with identical data
    send({25'h3F, 25'h21, 25'h05, 25'h03}, {25'h1F, 25'h11, 25'h07, 25'h01}, 25'h11, 1'b1, 1'b0);
    send({25'h3F, 25'h21, 25'h05, 25'h03}, {25'h1F, 25'h11, 25'h07, 25'h01}, 25'h11, 1'b0, 1'b0);
    send({25'h3F, 25'h21, 25'h05, 25'h03}, {25'h1F, 25'h11, 25'h07, 25'h01}, 25'h11, 1'b1, 1'b0);
    drain();

    // asynchronous reset with beats in flight
    send({4{25'h0FFFFFF}}, '0, 25'h0FFFFFF, 1'b0, 1'b0);
    send({25'd1, 25'd2, 25'd3, 25'd4}, '0, 25'd5, 1'b1, 1'b0);
    send({25'd7, 25'd7, 25'd7, 25'd7}, '0, 25'd7, 1'b0, 1'b0);
    #2;
    rst = 1;
    in_valid = 0;
    #1;
    check("async_out_valid", out_valid, 0);
    check("async_out_valid_b", out_valid_b, 0);
    check("async_out_data", out_data, 0);
    check("async_ovf_cnt", ovf_cnt, 0);
    check("async_in_ready", in_ready, 1);
    exp_q.delete();
    exp_b_q.delete();
    exp_ovf = 0;
    @(posedge clk);
    #3;
    rst = 0;
    latency_beat({25'd8, 25'd6, 25'd4, 25'd2}, '0, 25'h1FFFFFF, 1'b1);
    drain();

    // randomized traffic with random backpressure and bubbles
    for (int i = 0; i < 300; i++) begin
      for (int p = 0; p < NPE; p++) rp[p*DW +: DW] = rnd_val();
      for (int p = 0; p < 4; p++) rh[p*DW +: DW] = rnd_val();
      if ($urandom_range(0, 4) == 0)
        step(0, rp, rh, rnd_val(), 1'b0, $urandom_range(0, 3) != 0, acc);
      send(rp, rh, rnd_val(), $urandom_range(0, 1), 1'b1);
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
